// File: rtl/key_debouncer.sv
// Two-flop synchroniser and per-key debounce FSM for active-low pushbuttons, with press/release strobes.
// Optional auto-repeat on oPRESS is enabled by defining KEY_AUTOREPEAT_EN.
`default_nettype none

module key_debouncer #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             iCLK_50,
  input  logic             iRST_N,
  input  logic [NKEYS-1:0] iKEY,
  output logic [NKEYS-1:0] oKEY,
  output logic [NKEYS-1:0] oPRESS,
  output logic [NKEYS-1:0] oRELEASE
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_debouncer: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    UP       = 2'd0,
    CHK_DOWN = 2'd1,
    DOWN     = 2'd2,
    CHK_UP   = 2'd3
  } state_t;

  logic [NKEYS-1:0] meta;
  logic [NKEYS-1:0] sync;

  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      meta <= '1;
      sync <= '1;
    end else begin
      meta <= iKEY;
      sync <= meta;
    end
  end

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept_press;
    logic          accept_release;
    logic          level;
    logic          press_q;
    logic          release_q;
    logic          press_nxt;

    always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      accept_press   = 1'b0;
      accept_release = 1'b0;
      case (state)
        UP: begin
          if (!sync[k]) begin
            state_nxt = CHK_DOWN;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = '0;
          end
        end
        CHK_DOWN: begin
          if (sync[k]) begin
            state_nxt = UP;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt    = DOWN;
            cnt_nxt      = '0;
            accept_press = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DOWN: begin
          if (sync[k]) begin
            state_nxt = CHK_UP;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = '0;
          end
        end
        CHK_UP: begin
          if (!sync[k]) begin
            state_nxt = DOWN;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt      = UP;
            cnt_nxt        = '0;
            accept_release = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end
      endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX) + 1;
    localparam logic [RW-1:0] REP_D_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_P_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic          rphase;   // 0 while waiting out the initial delay, 1 once periodic
    logic          held;
    logic          rep_hit;

    assign held    = (state == DOWN) || (state == CHK_UP);
    assign rep_hit = held && (rphase ? (rcnt == REP_P_LAST) : (rcnt == REP_D_LAST));
    // A release accepted on the same edge wins over a repeat strobe.
    assign press_nxt = accept_press | (rep_hit & ~accept_release);

    always_ff @(posedge iCLK_50) begin
      if (!iRST_N || accept_press || !held) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (rep_hit) begin
        rcnt   <= '0;
        rphase <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
`else
    assign press_nxt = accept_press;
`endif

    always_ff @(posedge iCLK_50) begin
      if (!iRST_N) begin
        state     <= UP;
        cnt       <= '0;
        level     <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        press_q   <= press_nxt;
        release_q <= accept_release;
        if (accept_press) begin
          level <= 1'b0;
        end else if (accept_release) begin
          level <= 1'b1;
        end
      end
    end

    assign oKEY[k]     = level;
    assign oPRESS[k]   = press_q;
    assign oRELEASE[k] = release_q;
  end

endmodule

`default_nettype wire
